// File: rtl/ham_pkg.sv
// Shared SECDED Hamming definitions used by the encoder and decoder blocks.
package ham_pkg;

  // Decode outcome for one codeword
  typedef enum logic [1:0] {
    HAM_CLEAN       = 2'd0,
    HAM_SEC         = 2'd1,
    HAM_SEC_OVERALL = 2'd2,
    HAM_DED         = 2'd3
  } ham_class_e;

  // Smallest p with 2**p >= dw + p + 1
  function automatic int calc_parity_bits(input int dw);
    int p;
    p = 0;
    for (int q = 1; q < 31; q++) begin
      if ((p == 0) && ((32'sd1 << q) >= (dw + q + 1))) begin
        p = q;
      end
    end
    return p;
  endfunction

  // True for 1, 2, 4, 8, ... (parity positions of the codeword)
  function automatic logic is_pow2(input int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  // 1-based codeword position holding data bit j (data fills non-power-of-2 slots)
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int k = 1; k <= 4096; k++) begin
      if (!is_pow2(k)) begin
        if ((cnt == j) && (pos == 0)) begin
          pos = k;
        end
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ham_secded_core.sv
// Per-codeword SECDED datapath. The syndrome half feeds the S1 register,
// the classify/correct/extract half reads the S1 register and feeds S2.
module ham_secded_core
  import ham_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int PARITY_BITS  = calc_parity_bits(DATA_WIDTH),
  parameter int ENCODED_WORD = DATA_WIDTH + PARITY_BITS
) (
  input  logic [ENCODED_WORD:0]   raw_code,
  output logic [PARITY_BITS-1:0]  raw_syn,
  output logic                    raw_ov,
  input  logic [ENCODED_WORD:0]   s1_code,
  input  logic [PARITY_BITS-1:0]  s1_syn,
  input  logic                    s1_ov,
  output logic [DATA_WIDTH-1:0]   dec_data,
  output logic                    dec_sec,
  output logic                    dec_ded,
  output logic [PARITY_BITS-1:0]  dec_err_pos
);

  localparam logic [PARITY_BITS-1:0] MAX_POS  = PARITY_BITS'(ENCODED_WORD);
  localparam logic [PARITY_BITS-1:0] LAST_POS = PARITY_BITS'(ENCODED_WORD + 1);
  localparam logic [PARITY_BITS-1:0] ZERO_POS = {PARITY_BITS{1'b0}};

  ham_class_e              cls_s;
  logic [ENCODED_WORD:0]   fixed_s;

  // Syndrome = XOR of the positions of all set bits; overall parity over the whole stored word
  always_comb begin
    raw_syn = ZERO_POS;
    for (int k = 1; k <= ENCODED_WORD; k++) begin
      raw_syn = raw_syn ^ (raw_code[k-1] ? PARITY_BITS'(k) : ZERO_POS);
    end
    raw_ov = ^raw_code;
  end

  // Classify; a syndrome pointing past the last position cannot be a single error
  always_comb begin
    cls_s = HAM_DED;
    if ((s1_syn == ZERO_POS) && !s1_ov) begin
      cls_s = HAM_CLEAN;
    end else if ((s1_syn == ZERO_POS) && s1_ov) begin
      cls_s = HAM_SEC_OVERALL;
    end else if (s1_ov && (s1_syn <= MAX_POS)) begin
      cls_s = HAM_SEC;
    end else begin
      cls_s = HAM_DED;
    end
  end

  // Flip the bit named by the syndrome only for a correctable single error
  always_comb begin
    fixed_s = s1_code;
    for (int k = 1; k <= ENCODED_WORD; k++) begin
      fixed_s[k-1] = s1_code[k-1] ^ ((cls_s == HAM_SEC) && (s1_syn == PARITY_BITS'(k)));
    end
  end

  // Data bits come from the non-power-of-2 positions in ascending order
  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_extract
    assign dec_data[j] = fixed_s[data_pos(j) - 1];
  end

  // Per-class flags and reported error position
  always_comb begin
    dec_sec     = 1'b0;
    dec_ded     = 1'b0;
    dec_err_pos = ZERO_POS;
    case (cls_s)
      HAM_CLEAN: begin
        dec_sec = 1'b0;
      end
      HAM_SEC: begin
        dec_sec     = 1'b1;
        dec_err_pos = s1_syn;
      end
      HAM_SEC_OVERALL: begin
        dec_sec     = 1'b1;
        dec_err_pos = LAST_POS;
      end
      HAM_DED: begin
        dec_ded = 1'b1;
      end
      default: begin
        dec_ded = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ham_secded_pipe_dec.sv
// Two-stage pipelined SECDED decoder for NUM_PORTS codewords per beat, with
// valid/ready flow control and saturating SEC/DED event counters.
module ham_secded_pipe_dec
  import ham_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PARITY_BITS = calc_parity_bits(DATA_WIDTH),
  parameter int NUM_PORTS   = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_valid,
  output logic                                     o_ready,
  input  logic [NUM_PORTS*(DATA_WIDTH+PARITY_BITS+1)-1:0] i_code,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]          o_data,
  output logic [NUM_PORTS-1:0]                     o_sec,
  output logic [NUM_PORTS-1:0]                     o_ded,
  output logic [NUM_PORTS*PARITY_BITS-1:0]         o_err_pos,
  input  logic                                     i_clr_cnt,
  output logic [CNT_WIDTH-1:0]                     o_sec_count,
  output logic [CNT_WIDTH-1:0]                     o_ded_count,
  output logic                                     o_ded_sticky
);

  localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;
  localparam int CW           = ENCODED_WORD + 1;
  localparam int SUM_W        = CNT_WIDTH + $clog2(NUM_PORTS + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  // S1 registers
  logic                              s1_valid_r;
  logic [NUM_PORTS*CW-1:0]           s1_code_r;
  logic [NUM_PORTS*PARITY_BITS-1:0]  s1_syn_r;
  logic [NUM_PORTS-1:0]              s1_ov_r;

  // S2 (output) registers
  logic                              s2_valid_r;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   s2_data_r;
  logic [NUM_PORTS-1:0]              s2_sec_r;
  logic [NUM_PORTS-1:0]              s2_ded_r;
  logic [NUM_PORTS*PARITY_BITS-1:0]  s2_pos_r;

  logic [CNT_WIDTH-1:0]              sec_cnt_r;
  logic [CNT_WIDTH-1:0]              ded_cnt_r;
  logic                              sticky_r;

  // Combinational core outputs
  logic [NUM_PORTS*PARITY_BITS-1:0]  syn_s;
  logic [NUM_PORTS-1:0]              ov_s;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   dec_data_s;
  logic [NUM_PORTS-1:0]              dec_sec_s;
  logic [NUM_PORTS-1:0]              dec_ded_s;
  logic [NUM_PORTS*PARITY_BITS-1:0]  dec_pos_s;

  logic                              ready_s1_s;
  logic                              ready_s2_s;
  logic                              xfer_s;
  logic [SUM_W-1:0]                  sec_sum_s;
  logic [SUM_W-1:0]                  ded_sum_s;
  logic [CNT_WIDTH-1:0]              sec_next_s;
  logic [CNT_WIDTH-1:0]              ded_next_s;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    ham_secded_core #(
      .DATA_WIDTH   (DATA_WIDTH),
      .PARITY_BITS  (PARITY_BITS),
      .ENCODED_WORD (ENCODED_WORD)
    ) u_core (
      .raw_code    (i_code[n*CW +: CW]),
      .raw_syn     (syn_s[n*PARITY_BITS +: PARITY_BITS]),
      .raw_ov      (ov_s[n]),
      .s1_code     (s1_code_r[n*CW +: CW]),
      .s1_syn      (s1_syn_r[n*PARITY_BITS +: PARITY_BITS]),
      .s1_ov       (s1_ov_r[n]),
      .dec_data    (dec_data_s[n*DATA_WIDTH +: DATA_WIDTH]),
      .dec_sec     (dec_sec_s[n]),
      .dec_ded     (dec_ded_s[n]),
      .dec_err_pos (dec_pos_s[n*PARITY_BITS +: PARITY_BITS])
    );
  end

  // A stage may take a new beat when it is empty or its content leaves this cycle
  assign ready_s2_s = !s2_valid_r || i_ready;
  assign ready_s1_s = !s1_valid_r || ready_s2_s;
  assign xfer_s     = s2_valid_r && i_ready;

  assign o_ready      = ready_s1_s || i_rst;
  assign o_valid      = s2_valid_r;
  assign o_data       = s2_data_r;
  assign o_sec        = s2_sec_r;
  assign o_ded        = s2_ded_r;
  assign o_err_pos    = s2_pos_r;
  assign o_sec_count  = sec_cnt_r;
  assign o_ded_count  = ded_cnt_r;
  assign o_ded_sticky = sticky_r;

  // S1: capture raw codeword with its syndrome and overall parity
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r <= 1'b0;
      s1_code_r  <= {(NUM_PORTS*CW){1'b0}};
      s1_syn_r   <= {(NUM_PORTS*PARITY_BITS){1'b0}};
      s1_ov_r    <= {NUM_PORTS{1'b0}};
    end else if (ready_s1_s) begin
      s1_valid_r <= i_valid;
      if (i_valid) begin
        s1_code_r <= i_code;
        s1_syn_r  <= syn_s;
        s1_ov_r   <= ov_s;
      end
    end
  end

  // S2: register corrected data and flags; held stable while the consumer stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {(NUM_PORTS*DATA_WIDTH){1'b0}};
      s2_sec_r   <= {NUM_PORTS{1'b0}};
      s2_ded_r   <= {NUM_PORTS{1'b0}};
      s2_pos_r   <= {(NUM_PORTS*PARITY_BITS){1'b0}};
    end else if (ready_s2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= dec_data_s;
        s2_sec_r  <= dec_sec_s;
        s2_ded_r  <= dec_ded_s;
        s2_pos_r  <= dec_pos_s;
      end
    end
  end

  // Saturating next-count from the events of the beat being delivered
  always_comb begin
    sec_sum_s = SUM_W'(sec_cnt_r);
    ded_sum_s = SUM_W'(ded_cnt_r);
    for (int n = 0; n < NUM_PORTS; n++) begin
      sec_sum_s = sec_sum_s + SUM_W'(s2_sec_r[n]);
      ded_sum_s = ded_sum_s + SUM_W'(s2_ded_r[n]);
    end
    if (sec_sum_s > CNT_MAX) begin
      sec_next_s = {CNT_WIDTH{1'b1}};
    end else begin
      sec_next_s = sec_sum_s[CNT_WIDTH-1:0];
    end
    if (ded_sum_s > CNT_MAX) begin
      ded_next_s = {CNT_WIDTH{1'b1}};
    end else begin
      ded_next_s = ded_sum_s[CNT_WIDTH-1:0];
    end
  end

  // Event counters and DED sticky flag; clear takes priority over a same-cycle delivery
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_cnt) begin
      sec_cnt_r <= {CNT_WIDTH{1'b0}};
      ded_cnt_r <= {CNT_WIDTH{1'b0}};
      sticky_r  <= 1'b0;
    end else if (xfer_s) begin
      sec_cnt_r <= sec_next_s;
      ded_cnt_r <= ded_next_s;
      sticky_r  <= sticky_r || (|s2_ded_r);
    end
  end

endmodule

// File: tb/tb_ham_secded_pipe_dec.sv
// Scoreboard bench for ham_secded_pipe_dec: directed vectors, stalls,
// counter saturation/clear, mid-stream reset and randomized error injection.
module tb_ham_secded_pipe_dec;

  localparam int DW  = 32;
  localparam int NP  = 2;
  localparam int PB  = 6;
  localparam int CW  = 39;
  localparam int CNT = 4;
  localparam int CNT_MAX = (1 << CNT) - 1;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [NP*CW-1:0]  i_code;
  logic              o_valid;
  logic              i_ready;
  logic [NP*DW-1:0]  o_data;
  logic [NP-1:0]     o_sec;
  logic [NP-1:0]     o_ded;
  logic [NP*PB-1:0]  o_err_pos;
  logic              i_clr_cnt;
  logic [CNT-1:0]    o_sec_count;
  logic [CNT-1:0]    o_ded_count;
  logic              o_ded_sticky;

  ham_secded_pipe_dec #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .CNT_WIDTH(CNT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_code(i_code), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_sec(o_sec), .o_ded(o_ded), .o_err_pos(o_err_pos), .i_clr_cnt(i_clr_cnt),
    .o_sec_count(o_sec_count), .o_ded_count(o_ded_count), .o_ded_sticky(o_ded_sticky)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NP*DW-1:0] data;
    logic [NP-1:0]    sec;
    logic [NP-1:0]    ded;
    logic [NP*PB-1:0] pos;
    int               cyc;
    bit               lat_chk;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  int   sec_m   = 0;
  int   ded_m   = 0;
  bit   sticky_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference Hamming encoder: data in non-power-of-2 slots, parity p_i covers positions with bit i set
  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [CW-1:0] w;
    logic p;
    int j;
    w = '0;
    j = 0;
    for (int k = 1; k <= CW - 1; k++) begin
      if ((k & (k - 1)) != 0) begin
        w[k-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < PB; i++) begin
      p = 1'b0;
      for (int k = 1; k <= CW - 1; k++) if (k[i]) p = p ^ w[k-1];
      w[(1 << i) - 1] = p;
    end
    w[CW-1] = ^w[CW-2:0];
    return w;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [CW-1:0] w);
    logic [DW-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int k = 1; k <= CW - 1; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[j] = w[k-1];
        j++;
      end
    end
    return d;
  endfunction

  // Random beat: per port 0, 1 or 2 distinct bit flips; expectation follows from what was injected
  task automatic rand_beat(output logic [NP*CW-1:0] code, output exp_t e);
    e.data = '0; e.sec = '0; e.ded = '0; e.pos = '0; e.cyc = 0; e.lat_chk = 1'b0;
    code = '0;
    for (int p = 0; p < NP; p++) begin
      logic [DW-1:0] d;
      logic [CW-1:0] w;
      int n, a, b;
      d = $urandom;
      w = enc(d);
      n = $urandom_range(0, 9);
      a = $urandom_range(1, CW);
      b = $urandom_range(1, CW - 1);
      if (b >= a) b++;
      if (n < 4) begin
        e.data[p*DW +: DW] = d;
      end else if (n < 8) begin
        w[a-1] = ~w[a-1];
        e.data[p*DW +: DW] = d;
        e.sec[p] = 1'b1;
        e.pos[p*PB +: PB] = PB'(a);
      end else begin
        w[a-1] = ~w[a-1];
        w[b-1] = ~w[b-1];
        e.ded[p] = 1'b1;
        e.data[p*DW +: DW] = extract(w);
      end
      code[p*CW +: CW] = w;
    end
  endtask

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic drive(input logic v, input logic [NP*CW-1:0] code, input exp_t e,
                       input logic rdy, input logic clr, output bit acc);
    i_valid = v; i_code = code; i_ready = rdy; i_clr_cnt = clr;
    @(negedge i_clk);
    acc = v && o_ready && !i_rst;
    if (acc) begin
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [NP*CW-1:0] code, input exp_t e, input bit rnd_rdy, input int clr_pct);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      drive(1'b1, code, e, rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1,
            $urandom_range(0, 99) < clr_pct, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    bit acc;
    exp_t e;
    e = '{default: '0};
    drive(1'b0, '0, e, rdy, clr, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      idle(1'b1, 1'b0);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: counter model compare every cycle, beat compare on each output transfer
  always @(negedge i_clk) begin
    if (mon_en) begin
      chk("sec_count", 64'(o_sec_count), 64'(sec_m));
      chk("ded_count", 64'(o_ded_count), 64'(ded_m));
      chk("ded_sticky", 64'(o_ded_sticky), 64'(sticky_m));
      if (i_rst) begin
        q.delete();
        sec_m = 0; ded_m = 0; sticky_m = 1'b0;
      end else begin
        if (o_valid && i_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("o_data", o_data, e.data);
            chk("o_sec", 64'(o_sec), 64'(e.sec));
            chk("o_ded", 64'(o_ded), 64'(e.ded));
            chk("o_err_pos", 64'(o_err_pos), 64'(e.pos));
            if (e.lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd2);
            else           chk("latency_min", 64'(cyc - e.cyc >= 2), 64'd1);
          end
        end
        if (i_clr_cnt) begin
          sec_m = 0; ded_m = 0; sticky_m = 1'b0;
        end else if (o_valid && i_ready) begin
          sec_m = sec_m + int'(o_sec[0]) + int'(o_sec[1]);
          ded_m = ded_m + int'(o_ded[0]) + int'(o_ded[1]);
          if (sec_m > CNT_MAX) sec_m = CNT_MAX;
          if (ded_m > CNT_MAX) ded_m = CNT_MAX;
          if (|o_ded) sticky_m = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [NP*CW-1:0] code;
    logic [NP*CW-1:0] codes[4];
    exp_t             e;
    exp_t             es[4];
    bit               acc;
    int               k;
    int               n;

    i_rst = 1'b1; i_valid = 1'b0; i_code = '0; i_ready = 1'b1; i_clr_cnt = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("reset_o_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_data", o_data, 64'd0);
    chk("reset_flags", 64'({o_sec, o_ded, o_err_pos}), 64'd0);
    chk("reset_counts", 64'({o_sec_count, o_ded_count, o_ded_sticky}), 64'd0);
    mon_en = 1'b1;

    // Directed vectors
    e = '{default: '0};
    e.data = 64'h0000_0001_0000_0001; e.lat_chk = 1'b1;
    send({39'h40_0000_0007, 39'h40_0000_0007}, e, 1'b0, 0);
    e.lat_chk = 1'b0; e.sec = 2'b01; e.pos = 12'd5;
    send({39'h40_0000_0007, 39'h40_0000_0017}, e, 1'b0, 0);
    e.data = 64'h0000_0007_0000_0001; e.sec = 2'b00; e.ded = 2'b10; e.pos = 12'd0;
    send({39'h40_0000_0037, 39'h40_0000_0007}, e, 1'b0, 0);
    e.data = 64'h0000_0001_0000_0001; e.sec = 2'b01; e.ded = 2'b00; e.pos = 12'd39;
    send({39'h40_0000_0007, 39'h00_0000_0007}, e, 1'b0, 0);
    drain();
    chk("dir_sec_count", 64'(o_sec_count), 64'd2);
    chk("dir_ded_count", 64'(o_ded_count), 64'd1);
    chk("dir_sticky", 64'(o_ded_sticky), 64'd1);

    // Stall: consumer blocked for 5 cycles while 4 beats are offered
    for (int i = 0; i < 4; i++) begin
      rand_beat(codes[i], es[i]);
    end
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, codes[k], es[k], 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("stall_accepted", 64'(k), 64'd2);
    chk("stall_o_ready", 64'(o_ready), 64'd0);
    n = 0;
    while (k < 4 && n < 50) begin
      drive(1'b1, codes[k], es[k], 1'b1, 1'b0, acc);
      if (acc) k++;
      n++;
    end
    chk("stall_all_sent", 64'(k), 64'd4);
    drain();

    // Random traffic with backpressure and gaps; counters saturate
    for (int i = 0; i < 200; i++) begin
      rand_beat(code, e);
      send(code, e, 1'b1, 0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 1) != 0, 1'b0);
    end
    drain();
    chk("sat_sec_count", 64'(o_sec_count), 64'(CNT_MAX));
    chk("sat_ded_count", 64'(o_ded_count), 64'(CNT_MAX));

    // Clear in the same cycle as a delivery: clear wins
    rand_beat(code, e);
    drive(1'b1, code, e, 1'b0, 1'b0, acc);
    idle(1'b0, 1'b0);
    chk("clr_pending_valid", 64'(o_valid), 64'd1);
    idle(1'b1, 1'b1);
    chk("clr_sec_count", 64'(o_sec_count), 64'd0);
    chk("clr_ded_count", 64'(o_ded_count), 64'd0);
    chk("clr_sticky", 64'(o_ded_sticky), 64'd0);
    drain();

    // Random traffic with occasional clears
    for (int i = 0; i < 150; i++) begin
      rand_beat(code, e);
      send(code, e, 1'b1, 5);
    end

    // Reset mid-stream while the output is stalled with beats in flight
    for (int i = 0; i < 3; i++) begin
      rand_beat(code, e);
      drive(1'b1, code, e, 1'b0, 1'b0, acc);
    end
    i_rst = 1'b1;
    idle(1'b1, 1'b0);
    i_rst = 1'b0;
    chk("midrst_o_valid", 64'(o_valid), 64'd0);
    chk("midrst_o_ready", 64'(o_ready), 64'd1);
    chk("midrst_count", 64'(o_sec_count), 64'd0);
    idle(1'b1, 1'b0);
    chk("midrst_no_ghost", 64'(o_valid), 64'd0);

    for (int i = 0; i < 40; i++) begin
      rand_beat(code, e);
      send(code, e, 1'b1, 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
